// File: rtl/bsg_manycore_outstanding_tracker.sv
// Outstanding remote request tracker for a manycore tile.
// Counts accepted forward-network launches against return credits, throttles
// launches at max_out_p, runs a drain-to-zero fence handshake, and keeps a
// high-water mark plus sticky overflow/underflow flags for readback.
module bsg_manycore_outstanding_tracker #(
  parameter int max_out_p    = 32,
  parameter int data_width_p = 32,
  parameter int debug_p      = 0,
  localparam int cnt_width_lp = $clog2(max_out_p + 1)
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    launch_v_i,
  output logic                    launch_credit_o,
  input  logic                    ret_v_i,
  input  logic                    fence_v_i,
  output logic                    fence_busy_o,
  output logic                    fence_yumi_o,
  input  logic                    hwm_clr_i,
  output logic [data_width_p-1:0] count_o,
  output logic [data_width_p-1:0] hwm_o,
  output logic                    overflow_o,
  output logic                    underflow_o
);

  localparam logic [cnt_width_lp-1:0] max_cnt_lp = cnt_width_lp'(max_out_p);
  localparam logic [cnt_width_lp-1:0] one_lp     = cnt_width_lp'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    ACK   = 2'd2
  } state_e;

  state_e state_r, state_n;

  logic [cnt_width_lp-1:0] count_r, count_n;
  logic [cnt_width_lp-1:0] hwm_r;
  logic                    overflow_r, underflow_r;
  logic                    ovf_set, unf_set;

  // Next count: saturate at both ends and flag the offending event instead.
  always_comb begin
    count_n = count_r;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    if (launch_v_i & ~ret_v_i) begin
      if (count_r == max_cnt_lp) ovf_set = 1'b1;
      else                       count_n = count_r + one_lp;
    end else if (ret_v_i & ~launch_v_i) begin
      if (count_r == '0) unf_set = 1'b1;
      else               count_n = count_r - one_lp;
    end
  end

  // Count, high-water mark and sticky error flags.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_r     <= '0;
      hwm_r       <= '0;
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      count_r <= count_n;
      if (hwm_clr_i || (count_n > hwm_r)) hwm_r <= count_n;
      if (ovf_set) overflow_r  <= 1'b1;
      if (unf_set) underflow_r <= 1'b1;
    end
  end

  // Fence state register.
  always_ff @(posedge clk_i) begin
    if (reset_i) state_r <= IDLE;
    else         state_r <= state_n;
  end

  // Fence next-state: drain waits on the registered count, ACK lasts one cycle.
  always_comb begin
    state_n = state_r;
    case (state_r)
      IDLE:    if (fence_v_i) state_n = DRAIN;
      DRAIN:   if (count_r == '0) state_n = ACK;
      ACK:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Credit ignores same-cycle returns so it never depends on ret_v_i.
  assign launch_credit_o = (count_r < max_cnt_lp) && (state_r == IDLE);
  assign fence_busy_o    = (state_r != IDLE);
  assign fence_yumi_o    = (state_r == ACK);
  assign count_o         = data_width_p'(count_r);
  assign hwm_o           = data_width_p'(hwm_r);
  assign overflow_o      = overflow_r;
  assign underflow_o     = underflow_r;

  // Debug-only check that the core holds its fence request through the drain.
  always_ff @(posedge clk_i) begin
    if (!reset_i && (debug_p != 0) && (state_r == DRAIN))
      assert (fence_v_i);
  end

endmodule

// File: tb/tb_bsg_manycore_outstanding_tracker.sv
// Self-checking bench for bsg_manycore_outstanding_tracker.
// Main instance uses the default ceiling; extra instances cover max_out_p=4 and 1.
module tb_bsg_manycore_outstanding_tracker;

  localparam int MAXP = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance signals
  logic        reset = 1'b1, launch_v = 1'b0, ret_v = 1'b0, fence_v = 1'b0, hwm_clr = 1'b0;
  logic        credit, busy, yumi, ovf, unf;
  logic [31:0] count, hwm;

  // max_out_p = 4 instance signals
  logic        r4 = 1'b1, l4 = 1'b0, ret4 = 1'b0;
  logic        credit4, busy4, yumi4, ovf4, unf4;
  logic [31:0] count4, hwm4;

  // max_out_p = 1 instance signals
  logic        r1 = 1'b1, l1 = 1'b0, ret1 = 1'b0;
  logic        credit1, busy1, yumi1, ovf1, unf1;
  logic [31:0] count1, hwm1;

  bsg_manycore_outstanding_tracker dut (
    .clk_i(clk), .reset_i(reset), .launch_v_i(launch_v), .launch_credit_o(credit),
    .ret_v_i(ret_v), .fence_v_i(fence_v), .fence_busy_o(busy), .fence_yumi_o(yumi),
    .hwm_clr_i(hwm_clr), .count_o(count), .hwm_o(hwm), .overflow_o(ovf), .underflow_o(unf)
  );

  bsg_manycore_outstanding_tracker #(.max_out_p(4)) dut4 (
    .clk_i(clk), .reset_i(r4), .launch_v_i(l4), .launch_credit_o(credit4),
    .ret_v_i(ret4), .fence_v_i(1'b0), .fence_busy_o(busy4), .fence_yumi_o(yumi4),
    .hwm_clr_i(1'b0), .count_o(count4), .hwm_o(hwm4), .overflow_o(ovf4), .underflow_o(unf4)
  );

  bsg_manycore_outstanding_tracker #(.max_out_p(1)) dut1 (
    .clk_i(clk), .reset_i(r1), .launch_v_i(l1), .launch_credit_o(credit1),
    .ret_v_i(ret1), .fence_v_i(1'b0), .fence_busy_o(busy1), .fence_yumi_o(yumi1),
    .hwm_clr_i(1'b0), .count_o(count1), .hwm_o(hwm1), .overflow_o(ovf1), .underflow_o(unf1)
  );

  typedef struct {
    logic [31:0] count;
    logic [31:0] hwm;
    logic        ovf;
    logic        unf;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state for the main instance
  int   m_count = 0;
  int   m_hwm   = 0;
  logic m_ovf   = 1'b0;
  logic m_unf   = 1'b0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_count = 0; m_hwm = 0; m_ovf = 1'b0; m_unf = 1'b0;
    sb.delete();
  endtask

  // Drive one cycle on the main instance and push the model's expected result.
  task automatic drive(input logic l, input logic r, input logic c);
    exp_t e;
    launch_v = l; ret_v = r; hwm_clr = c;
    if (l && !r) begin
      if (m_count == MAXP) m_ovf = 1'b1;
      else                 m_count = m_count + 1;
    end else if (r && !l) begin
      if (m_count == 0) m_unf = 1'b1;
      else              m_count = m_count - 1;
    end
    if (c || (m_count > m_hwm)) m_hwm = m_count;
    e.count = 32'(m_count); e.hwm = 32'(m_hwm); e.ovf = m_ovf; e.unf = m_unf;
    sb.push_back(e);
    tick();
    launch_v = 1'b0; ret_v = 1'b0; hwm_clr = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; r4 = 1'b1; r1 = 1'b1;
    tick(); tick();
    model_reset();
    checks++; if (count !== 32'd0) begin errors++; $display("[TB] FAIL reset_count got %0d want 0", count); end
    checks++; if (hwm !== 32'd0) begin errors++; $display("[TB] FAIL reset_hwm got %0d want 0", hwm); end
    checks++; if ({ovf, unf, busy, yumi} !== 4'b0000) begin errors++; $display("[TB] FAIL reset_flags got %b want 0000", {ovf, unf, busy, yumi}); end
    reset = 1'b0; r4 = 1'b0; r1 = 1'b0;
    tick();
    checks++; if (credit !== 1'b1) begin errors++; $display("[TB] FAIL reset_credit got %b want 1", credit); end
  endtask

  task automatic test_launch_return();
    exp_t e;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, 1'b0);
      e = sb.pop_front();
      checks++; if (count !== e.count || hwm !== e.hwm) begin errors++; $display("[TB] FAIL launch_%0d got count=%0d hwm=%0d want count=%0d hwm=%0d", i, count, hwm, e.count, e.hwm); end
    end
    checks++; if (count !== 32'd5 || hwm !== 32'd5 || credit !== 1'b1) begin errors++; $display("[TB] FAIL after_5_launch got count=%0d hwm=%0d credit=%b want 5 5 1", count, hwm, credit); end
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b1, 1'b0);
      e = sb.pop_front();
      checks++; if (count !== e.count || hwm !== e.hwm) begin errors++; $display("[TB] FAIL return_%0d got count=%0d hwm=%0d want count=%0d hwm=%0d", i, count, hwm, e.count, e.hwm); end
    end
    checks++; if (count !== 32'd0 || hwm !== 32'd5) begin errors++; $display("[TB] FAIL after_5_return got count=%0d hwm=%0d want 0 5", count, hwm); end
  endtask

  task automatic test_overflow();
    logic exp_c;
    for (int i = 0; i < 4; i++) begin
      l4 = 1'b1; tick(); l4 = 1'b0;
      exp_c = (i < 3);
      checks++; if (count4 !== 32'(i + 1) || credit4 !== exp_c) begin errors++; $display("[TB] FAIL max4_launch_%0d got count=%0d credit=%b want %0d %b", i, count4, credit4, i + 1, exp_c); end
    end
    l4 = 1'b1; tick(); l4 = 1'b0;
    checks++; if (count4 !== 32'd4 || ovf4 !== 1'b1 || unf4 !== 1'b0) begin errors++; $display("[TB] FAIL max4_overflow got count=%0d ovf=%b unf=%b want 4 1 0", count4, ovf4, unf4); end
    tick();
    checks++; if (ovf4 !== 1'b1) begin errors++; $display("[TB] FAIL max4_sticky got ovf=%b want 1", ovf4); end
    r4 = 1'b1; tick(); r4 = 1'b0; tick();
    checks++; if (ovf4 !== 1'b0 || count4 !== 32'd0 || credit4 !== 1'b1) begin errors++; $display("[TB] FAIL max4_reset got ovf=%b count=%0d credit=%b want 0 0 1", ovf4, count4, credit4); end
  endtask

  task automatic test_max_one();
    for (int i = 0; i < 2; i++) begin
      l1 = 1'b1; tick(); l1 = 1'b0;
      checks++; if (credit1 !== 1'b0 || count1 !== 32'd1) begin errors++; $display("[TB] FAIL max1_launch_%0d got credit=%b count=%0d want 0 1", i, credit1, count1); end
      ret1 = 1'b1; tick(); ret1 = 1'b0;
      checks++; if (credit1 !== 1'b1 || count1 !== 32'd0) begin errors++; $display("[TB] FAIL max1_return_%0d got credit=%b count=%0d want 1 0", i, credit1, count1); end
    end
    checks++; if (ovf1 !== 1'b0 || unf1 !== 1'b0) begin errors++; $display("[TB] FAIL max1_flags got ovf=%b unf=%b want 0 0", ovf1, unf1); end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    for (int i = 0; i < 3; i++) begin drive(1'b1, 1'b0, 1'b0); void'(sb.pop_front()); end
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b1, 1'b0);
      e = sb.pop_front();
      checks++; if (count !== e.count || ovf !== e.ovf || unf !== e.unf) begin errors++; $display("[TB] FAIL concurrent_%0d got count=%0d want %0d", i, count, e.count); end
    end
    for (int i = 0; i < 3; i++) begin drive(1'b0, 1'b1, 1'b0); void'(sb.pop_front()); end
    drive(1'b0, 1'b1, 1'b0);
    e = sb.pop_front();
    checks++; if (count !== e.count || unf !== e.unf || ovf !== e.ovf) begin errors++; $display("[TB] FAIL underflow got count=%0d unf=%b ovf=%b want %0d %b %b", count, unf, ovf, e.count, e.unf, e.ovf); end
    checks++; if (unf !== 1'b1 || count !== 32'd0) begin errors++; $display("[TB] FAIL underflow_const got unf=%b count=%0d want 1 0", unf, count); end
  endtask

  task automatic test_fence_idle();
    fence_v = 1'b1; tick();
    checks++; if (busy !== 1'b1 || yumi !== 1'b0 || credit !== 1'b0) begin errors++; $display("[TB] FAIL fence_t1 got busy=%b yumi=%b credit=%b want 1 0 0", busy, yumi, credit); end
    tick();
    checks++; if (busy !== 1'b1 || yumi !== 1'b1) begin errors++; $display("[TB] FAIL fence_t2 got busy=%b yumi=%b want 1 1", busy, yumi); end
    fence_v = 1'b0; tick();
    checks++; if (busy !== 1'b0 || yumi !== 1'b0 || credit !== 1'b1) begin errors++; $display("[TB] FAIL fence_t3 got busy=%b yumi=%b credit=%b want 0 0 1", busy, yumi, credit); end
  endtask

  task automatic test_fence_drain();
    exp_t e;
    logic r, exp_y, exp_c, exp_b;
    for (int i = 0; i < 2; i++) begin drive(1'b1, 1'b0, 1'b0); void'(sb.pop_front()); end
    fence_v = 1'b1; tick();
    for (int k = 1; k <= 11; k++) begin
      exp_y = (k == 9);
      exp_c = (k >= 10);
      exp_b = (k <= 9);
      checks++; if (yumi !== exp_y || credit !== exp_c || busy !== exp_b) begin errors++; $display("[TB] FAIL drain_t%0d got yumi=%b credit=%b busy=%b want %b %b %b", k, yumi, credit, busy, exp_y, exp_c, exp_b); end
      fence_v = (k <= 9);
      r = (k == 4) || (k == 7);
      drive(1'b0, r, 1'b0);
      e = sb.pop_front();
      checks++; if (count !== e.count) begin errors++; $display("[TB] FAIL drain_count_t%0d got %0d want %0d", k + 1, count, e.count); end
    end
    fence_v = 1'b0;
  endtask

  task automatic test_hwm_clear();
    exp_t e;
    for (int i = 0; i < 7; i++) begin drive(1'b1, 1'b0, 1'b0); void'(sb.pop_front()); end
    for (int i = 0; i < 5; i++) begin drive(1'b0, 1'b1, 1'b0); void'(sb.pop_front()); end
    checks++; if (hwm !== 32'd7 || count !== 32'd2) begin errors++; $display("[TB] FAIL hwm_setup got hwm=%0d count=%0d want 7 2", hwm, count); end
    drive(1'b1, 1'b0, 1'b1);
    e = sb.pop_front();
    checks++; if (hwm !== e.hwm || count !== e.count) begin errors++; $display("[TB] FAIL hwm_clear got hwm=%0d count=%0d want %0d %0d", hwm, count, e.hwm, e.count); end
    checks++; if (hwm !== 32'd3) begin errors++; $display("[TB] FAIL hwm_clear_const got %0d want 3", hwm); end
  endtask

  task automatic test_reset_mid_fence();
    int yumi_seen;
    fence_v = 1'b1; tick(); tick();
    checks++; if (busy !== 1'b1 || credit !== 1'b0) begin errors++; $display("[TB] FAIL mid_fence_busy got busy=%b credit=%b want 1 0", busy, credit); end
    fence_v = 1'b0; reset = 1'b1; tick(); reset = 1'b0;
    model_reset();
    yumi_seen = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (yumi !== 1'b0) yumi_seen++;
    end
    checks++; if (yumi_seen !== 0) begin errors++; $display("[TB] FAIL mid_fence_yumi got %0d pulses want 0", yumi_seen); end
    checks++; if (busy !== 1'b0 || count !== 32'd0 || credit !== 1'b1 || unf !== 1'b0) begin errors++; $display("[TB] FAIL mid_fence_reset got busy=%b count=%0d credit=%b unf=%b want 0 0 1 0", busy, count, credit, unf); end
  endtask

  initial begin
    test_reset();
    test_launch_return();
    test_overflow();
    test_max_one();
    test_back_to_back();
    test_fence_idle();
    test_fence_drain();
    test_hwm_clear();
    test_reset_mid_fence();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
